// File: rtl/logic_op_arbiter_if.sv
// Request, operand, grant and result-handshake bundle between the client blocks
// and the shared logic-op arbiter.
interface logic_op_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8
);
    localparam int IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]       req_in;
    logic [2*NUM_REQ-1:0]     op_in;
    logic [WIDTH*NUM_REQ-1:0] a_in;
    logic [WIDTH*NUM_REQ-1:0] b_in;
    logic [NUM_REQ-1:0]       gnt_out;
    logic                     busy_out;
    logic [WIDTH-1:0]         y_out;
    logic [IDX_W-1:0]         y_id_out;
    logic                     y_valid_out;
    logic                     y_ready_in;

    modport master (
        output req_in, op_in, a_in, b_in, y_ready_in,
        input  gnt_out, busy_out, y_out, y_id_out, y_valid_out
    );

    modport slave (
        input  req_in, op_in, a_in, b_in, y_ready_in,
        output gnt_out, busy_out, y_out, y_id_out, y_valid_out
    );
endinterface

// File: rtl/logic_op_arbiter.sv
// Round-robin arbiter sharing one registered AND/OR/NOT/XOR unit among NUM_REQ
// requesters; one transaction at a time through IDLE -> EXEC -> RESP.
module logic_op_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    logic_op_arbiter_if.slave    bus
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam logic [NUM_REQ-1:0] GNT_LSB = {{(NUM_REQ-1){1'b0}}, 1'b1};
    localparam logic [IDX_W-1:0]   PTR_RST = IDX_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state_r, state_nxt_s;
    logic [IDX_W-1:0]   ptr_r, ptr_nxt_s;
    logic [IDX_W-1:0]   win_r, win_nxt_s;
    logic [1:0]         op_r, op_nxt_s;
    logic [WIDTH-1:0]   a_r, a_nxt_s;
    logic [WIDTH-1:0]   b_r, b_nxt_s;
    logic [WIDTH-1:0]   y_r, y_nxt_s;
    logic [IDX_W-1:0]   y_id_r, y_id_nxt_s;
    logic [NUM_REQ-1:0] gnt_r, gnt_nxt_s;
    logic               y_valid_r, y_valid_nxt_s;
    logic               busy_r, busy_nxt_s;

    logic [1:0]         op_arr_s [NUM_REQ];
    logic [WIDTH-1:0]   a_arr_s  [NUM_REQ];
    logic [WIDTH-1:0]   b_arr_s  [NUM_REQ];
    logic [IDX_W-1:0]   cand_s   [NUM_REQ];
    logic [IDX_W-1:0]   pick_s;
    logic               found_s;

    function automatic logic [WIDTH-1:0] logic_eval(
        input logic [1:0]       op,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic [WIDTH-1:0] r;
        case (op)
            2'b00:   r = a & b;
            2'b01:   r = a | b;
            2'b10:   r = ~a;
            2'b11:   r = a ^ b;
            default: r = {WIDTH{1'b0}};
        endcase
        return r;
    endfunction

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign op_arr_s[i] = bus.op_in[2*i +: 2];
        assign a_arr_s[i]  = bus.a_in[WIDTH*i +: WIDTH];
        assign b_arr_s[i]  = bus.b_in[WIDTH*i +: WIDTH];
    end

    // Search order: candidate k is the requester k+1 places after the last grant.
    always_comb begin
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_s[k] = IDX_W'((int'(ptr_r) + k + 1) % NUM_REQ);
        end
    end

    // Walking from the far end lets the nearest requesting candidate win.
    always_comb begin
        found_s = 1'b0;
        pick_s  = {IDX_W{1'b0}};
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            pick_s  = bus.req_in[cand_s[k]] ? cand_s[k] : pick_s;
            found_s = found_s | bus.req_in[cand_s[k]];
        end
    end

    // Sequencer next-state and next values of every registered output.
    always_comb begin
        state_nxt_s   = state_r;
        ptr_nxt_s     = ptr_r;
        win_nxt_s     = win_r;
        op_nxt_s      = op_r;
        a_nxt_s       = a_r;
        b_nxt_s       = b_r;
        y_nxt_s       = y_r;
        y_id_nxt_s    = y_id_r;
        y_valid_nxt_s = y_valid_r;
        gnt_nxt_s     = {NUM_REQ{1'b0}};
        case (state_r)
            IDLE: begin
                if (found_s) begin
                    win_nxt_s   = pick_s;
                    op_nxt_s    = op_arr_s[pick_s];
                    a_nxt_s     = a_arr_s[pick_s];
                    b_nxt_s     = b_arr_s[pick_s];
                    gnt_nxt_s   = GNT_LSB << pick_s;
                    state_nxt_s = EXEC;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            EXEC: begin
                y_nxt_s       = logic_eval(op_r, a_r, b_r);
                y_id_nxt_s    = win_r;
                y_valid_nxt_s = 1'b1;
                state_nxt_s   = RESP;
            end
            RESP: begin
                if (y_valid_r && bus.y_ready_in) begin
                    y_valid_nxt_s = 1'b0;
                    ptr_nxt_s     = win_r;
                    state_nxt_s   = IDLE;
                end else begin
                    state_nxt_s   = RESP;
                end
            end
            default: begin
                y_valid_nxt_s = 1'b0;
                state_nxt_s   = IDLE;
            end
        endcase
        busy_nxt_s = (state_nxt_s != IDLE);
    end

    // State and output registers; reset discards any in-flight transaction.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_r   <= IDLE;
            ptr_r     <= PTR_RST;
            win_r     <= {IDX_W{1'b0}};
            op_r      <= 2'b00;
            a_r       <= {WIDTH{1'b0}};
            b_r       <= {WIDTH{1'b0}};
            y_r       <= {WIDTH{1'b0}};
            y_id_r    <= {IDX_W{1'b0}};
            y_valid_r <= 1'b0;
            gnt_r     <= {NUM_REQ{1'b0}};
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            ptr_r     <= ptr_nxt_s;
            win_r     <= win_nxt_s;
            op_r      <= op_nxt_s;
            a_r       <= a_nxt_s;
            b_r       <= b_nxt_s;
            y_r       <= y_nxt_s;
            y_id_r    <= y_id_nxt_s;
            y_valid_r <= y_valid_nxt_s;
            gnt_r     <= gnt_nxt_s;
            busy_r    <= busy_nxt_s;
        end
    end

    assign bus.gnt_out     = gnt_r;
    assign bus.busy_out    = busy_r;
    assign bus.y_out       = y_r;
    assign bus.y_id_out    = y_id_r;
    assign bus.y_valid_out = y_valid_r;
endmodule

// File: doc/logic_op_arbiter.md
Name: logic_op_arbiter

Overview:
- Shares one registered bitwise logic unit (AND/OR/NOT/XOR) among NUM_REQ requesters.
- Uses round-robin arbitration, a 3-state sequencer and a valid/ready result handshake.
- Sits between the client blocks and the shared gate datapath. It sequences operand capture, evaluation and result return, one transaction at a time.

Parameters:
- NUM_REQ, 4: number of requesters, minimum 2.
- WIDTH, 8: operand and result width in bits.
- IDX_W, $clog2(NUM_REQ): requester index width. Derived; not overridden.

Ports:
- clk_in  input  1  clock, rising edge.
- rst_n_in  input  1  asynchronous, active-low reset.
- req_in  input  NUM_REQ  request per requester, level.
- op_in  input  2*NUM_REQ  opcode. Requester i uses bits [2i+1:2i].
- a_in  input  WIDTH*NUM_REQ  operand A. Requester i uses bits [WIDTH*i+WIDTH-1:WIDTH*i].
- b_in  input  WIDTH*NUM_REQ  operand B, same packing as a_in.
- gnt_out  output  NUM_REQ  one-hot grant, one-cycle pulse.
- busy_out  output  1  high whenever state is not IDLE.
- y_out  output  WIDTH  result.
- y_id_out  output  IDX_W  index of the requester owning y_out.
- y_valid_out  output  1  result valid.
- y_ready_in  input  1  result consumer ready.

Behaviour:
- Opcodes:
  - 00 AND: y = a & b.
  - 01 OR: y = a | b.
  - 10 NOT: y = ~a, b ignored.
  - 11 XOR: y = a ^ b.
  - All operations are bitwise over WIDTH; no carry and no width growth.
- Reset (async assert, any state):
  - state = IDLE.
  - gnt_out, y_out, y_id_out, y_valid_out and busy_out all = 0.
  - last-grant pointer = NUM_REQ-1, so requester 0 has top priority after reset.
  - An in-flight transaction is discarded; no partial result appears.
- Reset deassertion: synchronous to clk_in as seen by the logic. The first edge with rst_n_in high evaluates normally.
- FSM states: IDLE, EXEC, RESP. All outputs are registered.
- IDLE:
  - If any req_in bit is high at edge N, select the winner: the first set bit searching from (pointer+1) mod NUM_REQ upward with wrap.
  - At edge N: capture the winner's op, a and b into internal registers; set gnt_out to the winner's one-hot bit; latch the winner index; go to EXEC.
  - If no request, stay in IDLE with gnt_out = 0.
- EXEC:
  - gnt_out is high for exactly this one cycle (cycle N+1), then clears at the next edge.
  - At edge N+1: y_out = f(op, a, b), y_id_out = winner index, y_valid_out = 1; go to RESP.
- RESP:
  - y_out, y_id_out and y_valid_out hold stable until a handshake (y_valid_out and y_ready_in both high at an edge).
  - On handshake: y_valid_out = 0, pointer = winner index, go to IDLE. y_out and y_id_out keep their last value.
  - No arbitration happens in EXEC or RESP; gnt_out stays 0.
- Latency and throughput:
  - Request sampled at edge N: grant visible in cycle N+1, result valid from cycle N+2.
  - Minimum 3 cycles per transaction with y_ready_in tied high. The handshake edge returns to IDLE; the next grant is sampled at the following edge.
- Requester contract:
  - Hold req, op, a and b stable until gnt_out is seen.
  - Operands are sampled only at the grant edge; changes after that do not affect the result.
  - A req still high in IDLE after its own grant is treated as a new request at the lowest round-robin priority.
- Boundary conditions:
  - A request withdrawn before sampling is ignored.
  - Simultaneous requests follow round-robin order only; there is no fixed priority after reset.
  - Pointer wrap: NUM_REQ-1 is followed by 0.
  - y_ready_in high while y_valid_out is low has no effect.
- gnt_out is never more than one-hot; it is all-zero outside EXEC.

Test Plan:
1. Single request:
   - Stimulus: after reset, req_in=0100, op2=00, a2=0xF0, b2=0x3C, y_ready_in=1.
   - Response: gnt_out=0100 for exactly 1 cycle; next cycle y_out=0x30, y_id_out=2, y_valid_out=1 for 1 cycle; busy_out high for 2 cycles.
2. Opcode sweep:
   - Stimulus: requester 0 with a=0xA5, b=0x0F, op=00/01/10/11.
   - Response: y_out=0x05/0xAF/0x5A/0xAA respectively.
3. Round-robin fairness:
   - Stimulus: req_in=1111 held for 10 grants, y_ready_in=1.
   - Response: grant order 0,1,2,3,0,1,2,3,0,1; grants spaced 3 cycles apart.
4. Backpressure:
   - Stimulus: y_ready_in=0 for 6 cycles after y_valid_out rises, with req_in=1010 pending.
   - Response: y_out, y_id_out and y_valid_out stable; gnt_out stays 0; busy_out stays 1. After ready rises, the next grant goes to the next requester in round-robin order.
5. Pointer wrap and priority:
   - Stimulus: last grant to requester 3, then req_in=1001 simultaneously.
   - Response: requester 0 is granted first, then requester 3.
6. Reset mid-transaction:
   - Stimulus: assert rst_n_in=0 asynchronously during RESP.
   - Response: y_valid_out, y_out, gnt_out and busy_out go to 0 without waiting for a clock edge. After release, req_in=1111 grants requester 0 first.
